// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - SAP-1 opcodes, T-state encodings and control-word bit indices
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  localparam int CW_PC_OUT   = 0;
  localparam int CW_PC_INC   = 1;
  localparam int CW_PC_LOAD  = 2;
  localparam int CW_MAR_LOAD = 3;
  localparam int CW_MEM_OUT  = 4;
  localparam int CW_IR_LOAD  = 5;
  localparam int CW_IR_OUT   = 6;
  localparam int CW_ACC_LOAD = 7;
  localparam int CW_ACC_OUT  = 8;
  localparam int CW_B_LOAD   = 9;
  localparam int CW_ALU_OUT  = 10;
  localparam int CW_ALU_SUB  = 11;
  localparam int CW_OUT_LOAD = 12;
  localparam int CW_W        = 13;

endpackage

// File: rtl/ring_counter.sv
// rtl/ring_counter.sv - one-hot rotate-left ring with sync clear to bit0 and hold
module ring_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             hold_i,
  output logic [WIDTH-1:0] t_state_o
);

  logic [WIDTH-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = WIDTH'(1);
    end else if (!hold_i) begin
      state_d = {state_q[WIDTH-2:0], state_q[WIDTH-1]};
    end
  end

  always_ff @(posedge clk_i) begin
    state_q <= state_d;
  end

  assign t_state_o = state_q;

endmodule

// File: rtl/sap_controller.sv
// rtl/sap_controller.sv - SAP-1 sequencer: T-state ring plus opcode decode to control strobes
module sap_controller
  import sap_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int T_STATES = 6
) (
  input  logic                clk,
  input  logic                cls,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [T_STATES-1:0] t_state,
  output logic                pc_out,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                mar_load,
  output logic                mem_out,
  output logic                ir_load,
  output logic                ir_out,
  output logic                acc_load,
  output logic                acc_out,
  output logic                b_load,
  output logic                alu_out,
  output logic                alu_sub,
  output logic                out_load,
  output logic                halted
);

  logic            halted_q, halted_d;
  logic            hlt_exec;
  logic [CW_W-1:0] cw;

  // HLT returns the ring to T1 on the edge ending T4, then hold freezes it there.
  assign hlt_exec = t_state[3] && (opcode == OPCODE_W'(OP_HLT)) && !halted_q;

  ring_counter #(.WIDTH(T_STATES)) u_ring (
    .clk_i     (clk),
    .clear_i   (cls || hlt_exec),
    .hold_i    (halted_q),
    .t_state_o (t_state)
  );

  always_comb begin
    halted_d = halted_q;
    if (cls) begin
      halted_d = 1'b0;
    end else if (hlt_exec) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    halted_q <= halted_d;
  end

  always_comb begin
    cw = '0;
    if (t_state[0]) begin
      cw[CW_PC_OUT]   = 1'b1;
      cw[CW_MAR_LOAD] = 1'b1;
    end
    if (t_state[1]) cw[CW_PC_INC] = 1'b1;
    if (t_state[2]) begin
      cw[CW_MEM_OUT] = 1'b1;
      cw[CW_IR_LOAD] = 1'b1;
    end
    if (t_state[3]) begin
      case (opcode)
        OPCODE_W'(OP_LDA), OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB): begin
          cw[CW_IR_OUT]   = 1'b1;
          cw[CW_MAR_LOAD] = 1'b1;
        end
        OPCODE_W'(OP_JMP): begin
          cw[CW_IR_OUT]  = 1'b1;
          cw[CW_PC_LOAD] = 1'b1;
        end
        OPCODE_W'(OP_OUT): begin
          cw[CW_ACC_OUT]  = 1'b1;
          cw[CW_OUT_LOAD] = 1'b1;
        end
        default: ;
      endcase
    end
    if (t_state[4]) begin
      case (opcode)
        OPCODE_W'(OP_LDA): begin
          cw[CW_MEM_OUT]  = 1'b1;
          cw[CW_ACC_LOAD] = 1'b1;
        end
        OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB): begin
          cw[CW_MEM_OUT] = 1'b1;
          cw[CW_B_LOAD]  = 1'b1;
        end
        default: ;
      endcase
    end
    if (t_state[5]) begin
      if (opcode == OPCODE_W'(OP_ADD) || opcode == OPCODE_W'(OP_SUB)) begin
        cw[CW_ALU_OUT]  = 1'b1;
        cw[CW_ACC_LOAD] = 1'b1;
        cw[CW_ALU_SUB]  = (opcode == OPCODE_W'(OP_SUB));
      end
    end
    if (cls || halted_q) cw = '0;
  end

  assign pc_out   = cw[CW_PC_OUT];
  assign pc_inc   = cw[CW_PC_INC];
  assign pc_load  = cw[CW_PC_LOAD];
  assign mar_load = cw[CW_MAR_LOAD];
  assign mem_out  = cw[CW_MEM_OUT];
  assign ir_load  = cw[CW_IR_LOAD];
  assign ir_out   = cw[CW_IR_OUT];
  assign acc_load = cw[CW_ACC_LOAD];
  assign acc_out  = cw[CW_ACC_OUT];
  assign b_load   = cw[CW_B_LOAD];
  assign alu_out  = cw[CW_ALU_OUT];
  assign alu_sub  = cw[CW_ALU_SUB];
  assign out_load = cw[CW_OUT_LOAD];
  assign halted   = halted_q;

endmodule

// File: tb/tb_sap_controller.sv
// tb/tb_sap_controller.sv - directed self-checking bench for sap_controller
module tb_sap_controller;

  logic       clk = 1'b0;
  logic       cls;
  logic [3:0] opcode;
  logic [5:0] t_state;
  logic pc_out, pc_inc, pc_load, mar_load, mem_out, ir_load, ir_out;
  logic acc_load, acc_out, b_load, alu_out, alu_sub, out_load, halted;

  int checks = 0;
  int errors = 0;

  // Bench-side strobe packing, MSB first: pc_out pc_inc pc_load mar_load mem_out ir_load
  // ir_out acc_load acc_out b_load alu_out alu_sub out_load
  localparam logic [12:0] S_PC_OUT   = 13'h1000;
  localparam logic [12:0] S_PC_INC   = 13'h0800;
  localparam logic [12:0] S_PC_LOAD  = 13'h0400;
  localparam logic [12:0] S_MAR_LOAD = 13'h0200;
  localparam logic [12:0] S_MEM_OUT  = 13'h0100;
  localparam logic [12:0] S_IR_LOAD  = 13'h0080;
  localparam logic [12:0] S_IR_OUT   = 13'h0040;
  localparam logic [12:0] S_ACC_LOAD = 13'h0020;
  localparam logic [12:0] S_ACC_OUT  = 13'h0010;
  localparam logic [12:0] S_B_LOAD   = 13'h0008;
  localparam logic [12:0] S_ALU_OUT  = 13'h0004;
  localparam logic [12:0] S_ALU_SUB  = 13'h0002;
  localparam logic [12:0] S_OUT_LOAD = 13'h0001;
  localparam logic [12:0] S_NONE     = 13'h0000;

  localparam logic [12:0] F1 = S_PC_OUT | S_MAR_LOAD;
  localparam logic [12:0] F2 = S_PC_INC;
  localparam logic [12:0] F3 = S_MEM_OUT | S_IR_LOAD;

  logic [12:0] strobes;
  assign strobes = {pc_out, pc_inc, pc_load, mar_load, mem_out, ir_load, ir_out,
                    acc_load, acc_out, b_load, alu_out, alu_sub, out_load};

  sap_controller dut (
    .clk      (clk),
    .cls      (cls),
    .opcode   (opcode),
    .t_state  (t_state),
    .pc_out   (pc_out),
    .pc_inc   (pc_inc),
    .pc_load  (pc_load),
    .mar_load (mar_load),
    .mem_out  (mem_out),
    .ir_load  (ir_load),
    .ir_out   (ir_out),
    .acc_load (acc_load),
    .acc_out  (acc_out),
    .b_load   (b_load),
    .alu_out  (alu_out),
    .alu_sub  (alu_sub),
    .out_load (out_load),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One instruction from T1: pre_op held during fetch, op during execute.
  task automatic run_instr(input string tag, input logic [3:0] pre_op, input logic [3:0] op,
                           input logic [5:0][12:0] exp);
    for (int i = 0; i < 6; i++) begin
      opcode = (i < 3) ? pre_op : op;
      #1;
      check($sformatf("%s_t%0d_state", tag, i + 1), 32'(t_state), 32'(6'b1 << i));
      check($sformatf("%s_t%0d_cw", tag, i + 1), 32'(strobes), 32'(exp[i]));
      @(negedge clk);
    end
  endtask

  initial begin
    cls    = 1'b1;
    opcode = 4'b0000;
    repeat (2) begin
      @(negedge clk);
      #1 check("cls_cw_zero", 32'(strobes), 32'(S_NONE));
    end
    cls = 1'b0;
    #1;
    check("rst_state", 32'(t_state), 32'(6'b000001));
    check("rst_halted", 32'(halted), 32'(0));
    check("rst_cw", 32'(strobes), 32'(F1));

    run_instr("lda", 4'b1111, 4'b0000,
              {S_NONE, S_MEM_OUT | S_ACC_LOAD, S_IR_OUT | S_MAR_LOAD, F3, F2, F1});
    run_instr("add", 4'b0010, 4'b0001,
              {S_ALU_OUT | S_ACC_LOAD, S_MEM_OUT | S_B_LOAD, S_IR_OUT | S_MAR_LOAD, F3, F2, F1});
    run_instr("sub", 4'b0001, 4'b0010,
              {S_ALU_OUT | S_ACC_LOAD | S_ALU_SUB, S_MEM_OUT | S_B_LOAD, S_IR_OUT | S_MAR_LOAD,
               F3, F2, F1});
    run_instr("jmp", 4'b0000, 4'b0011,
              {S_NONE, S_NONE, S_IR_OUT | S_PC_LOAD, F3, F2, F1});
    run_instr("out", 4'b0000, 4'b1110,
              {S_NONE, S_NONE, S_ACC_OUT | S_OUT_LOAD, F3, F2, F1});
    run_instr("nop", 4'b0000, 4'b0101,
              {S_NONE, S_NONE, S_NONE, F3, F2, F1});

    // HLT: fetch, silent T4, then frozen at T1
    for (int i = 0; i < 4; i++) begin
      opcode = 4'b1111;
      #1;
      check($sformatf("hlt_t%0d_state", i + 1), 32'(t_state), 32'(6'b1 << i));
      check($sformatf("hlt_t%0d_cw", i + 1), 32'(strobes),
            32'((i == 0) ? F1 : (i == 1) ? F2 : (i == 2) ? F3 : S_NONE));
      @(negedge clk);
    end
    #1;
    check("hlt_halted", 32'(halted), 32'(1));
    for (int i = 0; i < 20; i++) begin
      opcode = 4'(i);
      #1;
      check("hlt_hold_state", 32'(t_state), 32'(6'b000001));
      check("hlt_hold_cw", 32'(strobes), 32'(S_NONE));
      @(negedge clk);
    end
    cls = 1'b1;
    #1 check("hlt_cls_cw", 32'(strobes), 32'(S_NONE));
    @(negedge clk);
    cls = 1'b0;
    #1;
    check("hlt_restart_halted", 32'(halted), 32'(0));
    check("hlt_restart_state", 32'(t_state), 32'(6'b000001));
    check("hlt_restart_cw", 32'(strobes), 32'(F1));

    // ADD abandoned by cls in T5
    for (int i = 0; i < 4; i++) begin
      opcode = 4'b0001;
      @(negedge clk);
    end
    #1;
    check("abort_t5_state", 32'(t_state), 32'(6'b010000));
    check("abort_t5_cw", 32'(strobes), 32'(S_MEM_OUT | S_B_LOAD));
    cls = 1'b1;
    #1 check("abort_cls_cw", 32'(strobes), 32'(S_NONE));
    @(negedge clk);
    cls = 1'b0;
    run_instr("after_abort", 4'b0001, 4'b0101,
              {S_NONE, S_NONE, S_NONE, F3, F2, F1});

    // Random non-halting opcodes, changed only at T1; structural invariants
    for (int i = 0; i < 200; i++) begin
      if (t_state == 6'b000001) opcode = 4'($urandom_range(0, 14));
      #1;
      check("rand_bus_1hot",
            32'($countones({pc_out, mem_out, ir_out, acc_out, alu_out}) <= 1), 32'(1));
      check("rand_inc_load", 32'(pc_inc & pc_load), 32'(0));
      check("rand_ring_1hot", 32'($countones(t_state)), 32'(1));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
